// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA test-pattern pixel stage.
//   rgb444_t   : packed {r,g,b} pixel, 4 bits per channel
//   pattern_e  : encodings of the selectable test patterns (6 and 7 are
//                reserved and render black)
//   COL_*      : the eight colour-bar colours plus the moving-bar background
//   H_ACTIVE_DEF / V_ACTIVE_DEF : visible area of 640x480
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [2:0] {
        SOLID   = 3'd0,
        BARS    = 3'd1,
        CHECKER = 3'd2,
        RAMP    = 3'd3,
        MOVBAR  = 3'd4,
        BORDER  = 3'd5
    } pattern_e;

    localparam rgb444_t COL_WHITE     = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb444_t COL_YELLOW    = '{r: 4'hF, g: 4'hF, b: 4'h0};
    localparam rgb444_t COL_CYAN      = '{r: 4'h0, g: 4'hF, b: 4'hF};
    localparam rgb444_t COL_GREEN     = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb444_t COL_MAGENTA   = '{r: 4'hF, g: 4'h0, b: 4'hF};
    localparam rgb444_t COL_RED       = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb444_t COL_BLUE      = '{r: 4'h0, g: 4'h0, b: 4'hF};
    localparam rgb444_t COL_BLACK     = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb444_t COL_DARK_BLUE = '{r: 4'h0, g: 4'h0, b: 4'h4};

    // Grey level: the same 4-bit value on all three channels.
    function automatic rgb444_t grey(input logic [3:0] level);
        rgb444_t c;
        c.r = level;
        c.g = level;
        c.b = level;
        return c;
    endfunction

endpackage

// File: rtl/vga_frame_tracker.sv
// -----------------------------------------------------------------------------
// vga_frame_tracker
// Detects the start of each frame from the (already registered) vsync and
// maintains the per-frame state: frame counter, moving-bar position and the
// active pattern mode, which only changes at a frame start.
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   vsync           : stage-1 registered vsync
//   mode_req        : requested pattern, captured on the frame-start cycle
//   frame_cnt       : frames seen since reset (wraps at 255)
//   bar_x           : left edge of the moving bar
//   mode            : pattern in force for the current frame
// -----------------------------------------------------------------------------
module vga_frame_tracker #(
    parameter int   H_ACTIVE  = 640,
    parameter int   BAR_STEP  = 4,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic [2:0] mode_req,
    output logic [7:0] frame_cnt,
    output logic [9:0] bar_x,
    output logic [2:0] mode
);

    localparam logic [10:0] STEP_W  = 11'(BAR_STEP);
    localparam logic [10:0] LIMIT_W = 11'(H_ACTIVE);

    logic        vsync_prev_r;
    logic        frame_start_s;
    logic [10:0] bar_sum_s;
    logic [9:0]  bar_next_s;

    // Frame start is the idle-to-active transition of the registered vsync.
    always_comb begin
        frame_start_s = (vsync_prev_r == SYNC_IDLE) && (vsync != SYNC_IDLE);
    end

    // Advance the bar, restarting at the left once it would pass the visible area.
    always_comb begin
        bar_sum_s = {1'b0, bar_x} + STEP_W;
        if (bar_sum_s >= LIMIT_W) begin
            bar_next_s = 10'd0;
        end else begin
            bar_next_s = bar_sum_s[9:0];
        end
    end

    // Per-frame state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_r <= SYNC_IDLE;
            frame_cnt    <= 8'd0;
            bar_x        <= 10'd0;
            mode         <= 3'd0;
        end else begin
            vsync_prev_r <= vsync;
            if (frame_start_s) begin
                frame_cnt <= frame_cnt + 8'd1;
                bar_x     <= bar_next_s;
                mode      <= mode_req;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// Pixel stage behind the 640x480@60 timing core. Decodes the active test
// pattern from Sx/Sy and emits RGB444 with de/hsync/vsync delayed to match,
// through a fixed two-stage pipeline (stage 1: timing + decoded pattern,
// stage 2: blanked RGB + timing).
// Ports:
//   i_VGA_CLOCK, i_rst          : pixel clock, synchronous active-high reset
//   i_de, i_hsync, i_vsync      : timing from the core
//   i_Sx, i_Sy                  : current column / row
//   i_mode                      : requested pattern (takes effect at frame start)
//   i_solid_rgb                 : {R,G,B} colour for the solid pattern
//   o_de, o_hsync, o_vsync      : timing delayed by 2 cycles
//   o_r, o_g, o_b               : pixel colour (0 while o_de is low)
//   o_frame_cnt                 : frames since reset, wrapping
// Optional build macro:
//   VGA_PATTERN_CROSSHAIR_EN    : red crosshair at the screen centre lines,
//                                 drawn over every pattern
// -----------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int   V_ACTIVE   = V_ACTIVE_DEF,
    parameter logic SYNC_IDLE  = 1'b1,
    parameter int   CHECK_LOG2 = 5,
    parameter int   BAR_STEP   = 4
) (
    input  logic        i_VGA_CLOCK,
    input  logic        i_rst,
    input  logic        i_de,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [9:0]  i_Sx,
    input  logic [9:0]  i_Sy,
    input  logic [2:0]  i_mode,
    input  logic [11:0] i_solid_rgb,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b,
    output logic [7:0]  o_frame_cnt
);

    localparam logic [9:0]  H_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [10:0] BAR_LEN = 11'd16;
    // Colour-bar edges: eight equal bars across the visible width.
    localparam int          BAR_W   = H_ACTIVE / 8;
    localparam logic [9:0]  EDGE1   = 10'(BAR_W * 1);
    localparam logic [9:0]  EDGE2   = 10'(BAR_W * 2);
    localparam logic [9:0]  EDGE3   = 10'(BAR_W * 3);
    localparam logic [9:0]  EDGE4   = 10'(BAR_W * 4);
    localparam logic [9:0]  EDGE5   = 10'(BAR_W * 5);
    localparam logic [9:0]  EDGE6   = 10'(BAR_W * 6);
    localparam logic [9:0]  EDGE7   = 10'(BAR_W * 7);

    logic        de1_r;
    logic        hs1_r;
    logic        vs1_r;
    rgb444_t     pat1_r;
    logic        de2_r;
    logic        hs2_r;
    logic        vs2_r;
    rgb444_t     rgb2_r;

    logic [2:0]  mode_s;
    logic [9:0]  bar_x_s;
    logic [7:0]  frame_cnt_s;
    rgb444_t     pat_s;
    rgb444_t     pix_s;
    logic        in_bar_s;
    logic [10:0] bar_end_s;

    vga_frame_tracker #(
        .H_ACTIVE  (H_ACTIVE),
        .BAR_STEP  (BAR_STEP),
        .SYNC_IDLE (SYNC_IDLE)
    ) u_tracker (
        .clk       (i_VGA_CLOCK),
        .rst       (i_rst),
        .vsync     (vs1_r),
        .mode_req  (i_mode),
        .frame_cnt (frame_cnt_s),
        .bar_x     (bar_x_s),
        .mode      (mode_s)
    );

    // Moving-bar window; columns past the visible area never count as bar.
    always_comb begin
        bar_end_s = {1'b0, bar_x_s} + BAR_LEN;
        in_bar_s  = (i_Sx >= bar_x_s) && ({1'b0, i_Sx} < bar_end_s) && (i_Sx <= H_LAST);
    end

    // Pattern decode for the pixel currently presented by the timing core.
    always_comb begin
        pat_s = COL_BLACK;
        case (mode_s)
            SOLID: begin
                pat_s = rgb444_t'(i_solid_rgb);
            end
            BARS: begin
                if (i_Sx < EDGE1) begin
                    pat_s = COL_WHITE;
                end else if (i_Sx < EDGE2) begin
                    pat_s = COL_YELLOW;
                end else if (i_Sx < EDGE3) begin
                    pat_s = COL_CYAN;
                end else if (i_Sx < EDGE4) begin
                    pat_s = COL_GREEN;
                end else if (i_Sx < EDGE5) begin
                    pat_s = COL_MAGENTA;
                end else if (i_Sx < EDGE6) begin
                    pat_s = COL_RED;
                end else if (i_Sx < EDGE7) begin
                    pat_s = COL_BLUE;
                end else begin
                    pat_s = COL_BLACK;
                end
            end
            CHECKER: begin
                if (i_Sx[CHECK_LOG2] ^ i_Sy[CHECK_LOG2]) begin
                    pat_s = COL_WHITE;
                end else begin
                    pat_s = COL_BLACK;
                end
            end
            RAMP: begin
                pat_s = grey(i_Sx[9:6]);
            end
            MOVBAR: begin
                if (in_bar_s) begin
                    pat_s = COL_WHITE;
                end else begin
                    pat_s = COL_DARK_BLUE;
                end
            end
            BORDER: begin
                if ((i_Sx == 10'd0) || (i_Sx == H_LAST) || (i_Sy == 10'd0) || (i_Sy == V_LAST)) begin
                    pat_s = COL_WHITE;
                end else begin
                    pat_s = COL_BLACK;
                end
            end
            default: begin
                pat_s = COL_BLACK;
            end
        endcase
    end

`ifdef VGA_PATTERN_CROSSHAIR_EN
    localparam logic [9:0] H_MID = 10'(H_ACTIVE / 2);
    localparam logic [9:0] V_MID = 10'(V_ACTIVE / 2);

    // Crosshair overlay on the centre column and centre row.
    always_comb begin
        if ((i_Sx == H_MID) || (i_Sy == V_MID)) begin
            pix_s = COL_RED;
        end else begin
            pix_s = pat_s;
        end
    end
`else
    // No overlay: the pattern passes straight through.
    always_comb begin
        pix_s = pat_s;
    end
`endif

    // Stage 1: register timing and the decoded pattern.
    always_ff @(posedge i_VGA_CLOCK) begin
        if (i_rst) begin
            de1_r  <= 1'b0;
            hs1_r  <= SYNC_IDLE;
            vs1_r  <= SYNC_IDLE;
            pat1_r <= COL_BLACK;
        end else begin
            de1_r  <= i_de;
            hs1_r  <= i_hsync;
            vs1_r  <= i_vsync;
            pat1_r <= pix_s;
        end
    end

    // Stage 2: blank RGB outside the active area and delay timing once more.
    always_ff @(posedge i_VGA_CLOCK) begin
        if (i_rst) begin
            de2_r  <= 1'b0;
            hs2_r  <= SYNC_IDLE;
            vs2_r  <= SYNC_IDLE;
            rgb2_r <= COL_BLACK;
        end else begin
            de2_r  <= de1_r;
            hs2_r  <= hs1_r;
            vs2_r  <= vs1_r;
            rgb2_r <= de1_r ? pat1_r : COL_BLACK;
        end
    end

    assign o_de        = de2_r;
    assign o_hsync     = hs2_r;
    assign o_vsync     = vs2_r;
    assign o_r         = rgb2_r.r;
    assign o_g         = rgb2_r.g;
    assign o_b         = rgb2_r.b;
    assign o_frame_cnt = frame_cnt_s;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
// Scoreboard bench: each driven cycle pushes the expected output word
// {de,hsync,vsync,rgb,frame_cnt} from a behavioural model; the word is popped
// and compared two clocks later. Frames are compressed (short vsync pulses
// and a handful of chosen pixels) to keep the run short.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

    localparam logic IDLE = 1'b1;
    localparam logic ACT  = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic        hs;
    logic        vs;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [2:0]  mode;
    logic [11:0] solid;
    logic        o_de;
    logic        o_hsync;
    logic        o_vsync;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;
    logic [7:0]  o_frame_cnt;

    always #20 clk = ~clk;

    vga_pattern_gen dut (
        .i_VGA_CLOCK (clk),
        .i_rst       (rst),
        .i_de        (de),
        .i_hsync     (hs),
        .i_vsync     (vs),
        .i_Sx        (sx),
        .i_Sy        (sy),
        .i_mode      (mode),
        .i_solid_rgb (solid),
        .o_de        (o_de),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b),
        .o_frame_cnt (o_frame_cnt)
    );

    typedef struct {
        logic [22:0] word;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state
    int   m_cnt;
    int   m_bar;
    int   m_mode;
    logic m_prev_vs;
    bit   m_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model_pix(input int md, input int x, input int y,
                                              input int bar, input logic [11:0] sol);
        logic [11:0] bars [8];
        logic [3:0]  lvl;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`ifdef VGA_PATTERN_CROSSHAIR_EN
        if (x == 320 || y == 240) return 12'hF00;
`endif
        case (md)
            0: return sol;
            1: return (x < 640) ? bars[x / 80] : 12'h000;
            2: return ((((x >> 5) ^ (y >> 5)) & 1) == 1) ? 12'hFFF : 12'h000;
            3: begin
                lvl = 4'((x >> 6) & 15);
                return {lvl, lvl, lvl};
            end
            4: return (x >= bar && x < bar + 16 && x < 640) ? 12'hFFF : 12'h004;
            5: return (x == 0 || x == 639 || y == 0 || y == 479) ? 12'hFFF : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    // Drive one cycle of inputs, predict its output, and compare the word due now.
    task automatic drive(input logic d, input logic h, input logic v,
                         input int x, input int y, input string tag);
        exp_t        e;
        exp_t        got_e;
        logic [11:0] rgb;
        logic        newframe;
        newframe  = (m_prev_vs == IDLE) && (v == ACT);
        m_prev_vs = v;
        rgb = d ? model_pix(m_mode, x, y, m_bar, solid) : 12'h000;
        if (m_pending) begin
            m_mode    = int'(mode);
            m_bar     = (m_bar + 4 >= 640) ? 0 : m_bar + 4;
            m_pending = 1'b0;
        end
        if (newframe) begin
            m_cnt     = (m_cnt + 1) % 256;
            m_pending = 1'b1;
        end
        e.word = {d, h, v, rgb, 8'(m_cnt)};
        e.tag  = tag;
        q.push_back(e);
        de = d; hs = h; vs = v; sx = 10'(x); sy = 10'(y);
        @(posedge clk);
        #1;
        if (q.size() > 1) begin
            got_e = q.pop_front();
            check(got_e.tag, {9'd0, o_de, o_hsync, o_vsync, o_r, o_g, o_b, o_frame_cnt},
                  {9'd0, got_e.word});
        end
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rgb", {20'd0, o_r, o_g, o_b}, 32'd0);
        check("rst_de", {31'd0, o_de}, 32'd0);
        check("rst_syncs", {30'd0, o_hsync, o_vsync}, {30'd0, IDLE, IDLE});
        check("rst_cnt", {24'd0, o_frame_cnt}, 32'd0);
        m_cnt = 0; m_bar = 0; m_mode = 0; m_prev_vs = IDLE; m_pending = 1'b0;
        e.word = {1'b0, IDLE, IDLE, 12'h000, 8'd0};
        e.tag  = "post_rst";
        q.push_back(e);
    endtask

    task automatic frame();
        drive(1'b0, IDLE, IDLE, 700, 485, "fr_pre");
        drive(1'b0, IDLE, ACT,  700, 490, "fr_vs0");
        drive(1'b0, IDLE, ACT,  700, 491, "fr_vs1");
        drive(1'b0, IDLE, IDLE, 700, 0,   "fr_post");
    endtask

    initial begin
        int xs1 [11];
        rst = 1'b0; de = 1'b0; hs = IDLE; vs = IDLE; sx = 10'd0; sy = 10'd0;
        mode = 3'd0; solid = 12'h5A3;
        m_cnt = 0; m_bar = 0; m_mode = 0; m_prev_vs = IDLE; m_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Solid colour: blank during de low, colour during de high.
        for (int i = 0; i < 4; i++) drive(1'b0, IDLE, IDLE, 650 + i, 10, "solid_blank");
        for (int i = 0; i < 4; i++) drive(1'b1, IDLE, IDLE, 100 + i, 10, "solid_act");
        drive(1'b0, ACT, IDLE, 660, 10, "solid_hs");

        // Colour bars on line 0, plus an hsync pulse.
        mode = 3'd1;
        frame();
        xs1 = '{0, 1, 79, 80, 160, 240, 320, 400, 480, 560, 639};
        foreach (xs1[i]) drive(1'b1, IDLE, IDLE, xs1[i], 0, "bars");
        drive(1'b0, IDLE, IDLE, 650, 0, "bars_fp");
        for (int i = 0; i < 3; i++) drive(1'b0, ACT, IDLE, 660 + i, 0, "bars_hs");
        drive(1'b0, IDLE, IDLE, 760, 0, "bars_bp");

        // Mid-frame mode request is ignored until the next frame start.
        drive(1'b1, IDLE, IDLE, 0, 100, "mchg_before");
        mode = 3'd2;
        drive(1'b1, IDLE, IDLE, 80, 100, "mchg_at");
        drive(1'b1, IDLE, IDLE, 400, 100, "mchg_after");
        drive(1'b1, IDLE, IDLE, 200, 300, "mchg_later");
        frame();
        drive(1'b1, IDLE, IDLE, 32, 0, "chk_32_0");
        drive(1'b1, IDLE, IDLE, 0, 0, "chk_0_0");
        drive(1'b1, IDLE, IDLE, 32, 32, "chk_32_32");
        drive(1'b1, IDLE, IDLE, 320, 5, "xh_col");
        drive(1'b1, IDLE, IDLE, 40, 240, "xh_row");
        drive(1'b1, IDLE, IDLE, 321, 241, "xh_off");

        // Grey ramp, border and reserved modes.
        mode = 3'd3;
        frame();
        drive(1'b1, IDLE, IDLE, 63, 7, "ramp");
        drive(1'b1, IDLE, IDLE, 64, 7, "ramp");
        drive(1'b1, IDLE, IDLE, 639, 7, "ramp");
        mode = 3'd5;
        frame();
        drive(1'b1, IDLE, IDLE, 0, 50, "border");
        drive(1'b1, IDLE, IDLE, 639, 50, "border");
        drive(1'b1, IDLE, IDLE, 50, 479, "border");
        drive(1'b1, IDLE, IDLE, 50, 50, "border_in");
        mode = 3'd6;
        frame();
        drive(1'b1, IDLE, IDLE, 5, 5, "reserved");

        // Reset in the middle of an active line.
        drive(1'b1, IDLE, IDLE, 200, 60, "pre_rst");
        drive(1'b1, IDLE, IDLE, 201, 60, "pre_rst");
        do_reset();
        drive(1'b1, IDLE, IDLE, 10, 10, "rst_solid");
        drive(1'b1, IDLE, IDLE, 11, 10, "rst_solid");

        // Moving bar over three frames, then to its wrap point.
        mode = 3'd4;
        for (int i = 0; i < 3; i++) frame();
        check("cnt_3", {24'd0, o_frame_cnt}, 32'd3);
        drive(1'b1, IDLE, IDLE, 11, 3, "mb_11");
        drive(1'b1, IDLE, IDLE, 12, 3, "mb_12");
        drive(1'b1, IDLE, IDLE, 27, 3, "mb_27");
        drive(1'b1, IDLE, IDLE, 28, 3, "mb_28");
        for (int i = 3; i < 159; i++) frame();
        drive(1'b1, IDLE, IDLE, 635, 3, "mb_635");
        drive(1'b1, IDLE, IDLE, 636, 3, "mb_636");
        drive(1'b1, IDLE, IDLE, 639, 3, "mb_639");
        frame();
        drive(1'b1, IDLE, IDLE, 0, 3, "mb_wrap0");
        drive(1'b1, IDLE, IDLE, 15, 3, "mb_wrap15");
        drive(1'b1, IDLE, IDLE, 16, 3, "mb_wrap16");
        drive(1'b1, IDLE, IDLE, 636, 3, "mb_wrap636");

        // Frame counter wraps after 256 frames.
        for (int i = 160; i < 256; i++) frame();
        check("cnt_wrap", {24'd0, o_frame_cnt}, 32'd0);
        drive(1'b0, IDLE, IDLE, 700, 0, "drain");
        drive(1'b0, IDLE, IDLE, 700, 0, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Downstream pixel stage for the 640x480@60 Hz VGA timing core. Consumes its timing outputs (de, hsync, vsync, Sx, Sy) and produces RGB444 pixels from a selectable test pattern.
- Delays hsync, vsync and de so they stay aligned with the pixel data.
- Keeps a frame counter, which drives the animated pattern and mode switching that only takes effect at frame boundaries.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- SYNC_IDLE, 1'b1, inactive level of hsync/vsync (640x480 syncs are negative polarity).
- CHECK_LOG2, 5, checkerboard square size = 2**CHECK_LOG2 pixels.
- BAR_STEP, 4, moving-bar advance per frame, in pixels.

Ports:
- i_VGA_CLOCK  in  1  pixel clock, 25.175 MHz.
- i_rst  in  1  reset, synchronous, active-high.
- i_de  in  1  display enable from the timing core.
- i_hsync  in  1  horizontal sync from the timing core.
- i_vsync  in  1  vertical sync from the timing core.
- i_Sx  in  10  current column, 0-799.
- i_Sy  in  10  current row, 0-524.
- i_mode  in  3  requested pattern.
- i_solid_rgb  in  12  colour for solid mode, as {R,G,B} 4 bits each.
- o_de  out  1  de delayed by 2 cycles.
- o_hsync  out  1  hsync delayed by 2 cycles.
- o_vsync  out  1  vsync delayed by 2 cycles.
- o_r  out  4  red.
- o_g  out  4  green.
- o_b  out  4  blue.
- o_frame_cnt  out  8  frames seen since reset; wraps.

Behaviour:
- Reset (i_rst high at a clock edge): o_r/o_g/o_b=0, o_de=0, o_hsync=o_vsync=SYNC_IDLE, o_frame_cnt=0, active mode=0, bar_x=0, pipeline flushed to these idle values. Reset can arrive mid-line or mid-frame with the same result; no partial pixel is emitted afterwards.
- Pipeline: fixed latency of 2 cycles from inputs to all outputs.
  - Stage 1 registers de/syncs/Sx/Sy and the decoded pattern terms.
  - Stage 2 registers RGB and the delayed timing signals.
- Blanking: RGB = 0 whenever the stage-2 de is 0, whatever the mode.
- Frame start: a single-cycle pulse when the registered i_vsync goes from SYNC_IDLE to active. On that pulse:
  - frame_cnt += 1 (255 wraps to 0);
  - bar_x += BAR_STEP; if the sum is >= H_ACTIVE, bar_x = 0;
  - active mode <= i_mode.
- Mode rules:
  - i_mode changes between frame starts have no effect on the current frame.
  - If a change coincides with the frame-start cycle, it is captured for the new frame.
- Patterns (active mode):
  - 0 solid: RGB = i_solid_rgb, sampled in stage 1.
  - 1 colour bars: eight bars, 80 px each, selected by Sx comparisons (no divider). Order: white F/F/F, yellow F/F/0, cyan 0/F/F, green 0/F/0, magenta F/0/F, red F/0/0, blue 0/0/F, black.
  - 2 checkerboard: white if Sx[CHECK_LOG2]^Sy[CHECK_LOG2] is 1, else black.
  - 3 grey ramp: R=G=B=Sx[9:6] (0-9 across 640 px).
  - 4 moving bar: white where bar_x <= Sx < bar_x+16, else dark blue 0/0/4. The bar is clipped at H_ACTIVE-1.
  - 5 border: white where Sx==0, Sx==H_ACTIVE-1, Sy==0 or Sy==V_ACTIVE-1; black inside.
  - 6, 7 reserved: output black.
- Input handling:
  - i_Sx/i_Sy values outside the active area are don't-care, because they are masked by de.
  - No combinational path from any input to any output.

Optional Feature:
- Macro: VGA_PATTERN_CROSSHAIR_EN.
- Defined: pixels with Sx==H_ACTIVE/2 or Sy==V_ACTIVE/2 (and de=1) are forced to red F/0/0 over every mode, including reserved modes. Latency is unchanged.
- Undefined: no overlay logic; output depends on the pattern only.

Decomposition:
- Package vga_pkg holds:
  - typedef rgb444_t, a struct {r,g,b} of 4 bits each;
  - enum pattern_e: SOLID, BARS, CHECKER, RAMP, MOVBAR, BORDER;
  - constants for the 8 bar colours;
  - H_ACTIVE/V_ACTIVE defaults.
- One sub-module, vga_frame_tracker: vsync edge detect, frame_cnt, bar_x and the mode shadow register. The top level holds the pattern decode and the 2-stage pipeline.

Test Plan:
1. Reset, then drive the real timing core with mode=1 → on line 0, pixels at Sx=0,80,400,639 appear 2 cycles later as FFF, FF0, F00, 000. o_hsync matches i_hsync delayed by exactly 2 cycles.
2. Mode=0, i_solid_rgb=12'h5A3, de low → RGB=000 throughout blanking. de high → 5/A/3.
3. Mode=4, run 3 frames → o_frame_cnt=3, bar_x=12. Next frame, pixel Sx=12 is white and Sx=28 is 0/0/4. Force bar_x=636 at a frame start → bar_x wraps to 0.
4. Change i_mode 1→2 mid-frame at Sy=100 → output stays bars until the next vsync edge, then shows checker: (Sx=32,Sy=0)=FFF, (0,0)=000.
5. Assert i_rst for 1 cycle mid-line → next-cycle outputs: RGB=0, de=0, syncs=1, frame_cnt=0, mode=solid. Run 256 frames → frame_cnt wraps to 0.
6. With VGA_PATTERN_CROSSHAIR_EN defined and mode=2 → pixels (320,y) and (x,240) are F00. Without the macro, the same pixels follow the checker.
